// File: rtl/id_ex_if.sv
// ID/EX stage bundle: IF/ID input, register-file port, write-back port and EX outputs.
interface id_ex_if;
    // IF/ID side
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        flush;
    logic        id_stall;
    // Register-file read port
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    // Write-back port
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    // EX pipeline register outputs
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_branch;
    logic        ex_illegal;

    // Driver of the pipeline around the stage
    modport master (
        output id_valid, id_instr, id_pc, flush, rf_rdata1, rf_rdata2,
               wb_we, wb_waddr, wb_wdata,
        input  rf_raddr1, rf_raddr2, id_stall,
               ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_alu_op, ex_funct, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_illegal
    );

    // The decode stage itself
    modport slave (
        input  id_valid, id_instr, id_pc, flush, rf_rdata1, rf_rdata2,
               wb_we, wb_waddr, wb_wdata,
        output rf_raddr1, rf_raddr2, id_stall,
               ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_alu_op, ex_funct, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode stage with operand read/bypass, load-use stall and ID/EX pipeline register.
module id_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    id_ex_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    logic [5:0]      opcode;
    logic [RW-1:0]   rs, rt, rd;
    logic [XLEN-1:0] imm_sext;

    logic [RW-1:0]   dec_dest;
    logic [1:0]      dec_alu_op;
    logic [5:0]      dec_funct;
    logic            dec_alu_src, dec_mem_read, dec_mem_write;
    logic            dec_reg_write, dec_branch, dec_illegal, dec_uses_rt;

    logic            hazard;
    logic            stall;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [XLEN-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [RW-1:0]   ex_rs_q, ex_rs_d;
    logic [RW-1:0]   ex_rt_q, ex_rt_d;
    logic [RW-1:0]   ex_dest_q, ex_dest_d;
    logic [1:0]      ex_alu_op_q, ex_alu_op_d;
    logic [5:0]      ex_funct_q, ex_funct_d;
    logic            ex_alu_src_q, ex_alu_src_d;
    logic            ex_mem_read_q, ex_mem_read_d;
    logic            ex_mem_write_q, ex_mem_write_d;
    logic            ex_reg_write_q, ex_reg_write_d;
    logic            ex_branch_q, ex_branch_d;
    logic            ex_illegal_q, ex_illegal_d;

    // Register 0 reads as zero; a same-cycle write-back overrides the stale array value.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [RW-1:0]   addr,
        input logic [XLEN-1:0] rdata,
        input logic            we,
        input logic [RW-1:0]   waddr,
        input logic [XLEN-1:0] wdata
    );
        if (addr == '0)                  return '0;
        else if (we && (waddr == addr))  return wdata;
        else                             return rdata;
    endfunction

    assign opcode   = bus.id_instr[31:26];
    assign rs       = bus.id_instr[25:21];
    assign rt       = bus.id_instr[20:16];
    assign rd       = bus.id_instr[15:11];
    assign imm_sext = {{(XLEN-16){bus.id_instr[15]}}, bus.id_instr[15:0]};

    assign bus.rf_raddr1 = rs;
    assign bus.rf_raddr2 = rt;

    // Instruction decode into EX controls; unknown opcodes flag illegal only.
    always_comb begin
        dec_dest      = '0;
        dec_alu_op    = ALU_ADD;
        dec_funct     = '0;
        dec_alu_src   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_branch    = 1'b0;
        dec_illegal   = 1'b0;
        dec_uses_rt   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_dest      = rd;
                dec_reg_write = 1'b1;
                dec_alu_op    = ALU_FUNCT;
                dec_funct     = bus.id_instr[5:0];
                dec_uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec_dest      = rt;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_LW: begin
                dec_dest      = rt;
                dec_alu_src   = 1'b1;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_branch    = 1'b1;
                dec_alu_op    = ALU_SUB;
                dec_uses_rt   = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Writes to $0 are dropped at decode so later stages never see them.
        if (dec_dest == '0) dec_reg_write = 1'b0;
    end

    // Load-use hazard against the load currently in EX; a flush suppresses the stall.
    assign hazard = bus.id_valid && ex_valid_q && ex_mem_read_q && (ex_dest_q != '0) &&
                    ((ex_dest_q == rs) || (dec_uses_rt && (ex_dest_q == rt)));
    assign stall        = hazard && !bus.flush;
    assign bus.id_stall = stall;

    // Next EX register contents: bubble on flush/stall, else the decoded instruction.
    always_comb begin
        ex_valid_d     = 1'b0;
        ex_pc_d        = '0;
        ex_rs_data_d   = '0;
        ex_rt_data_d   = '0;
        ex_imm_d       = '0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_dest_d      = '0;
        ex_alu_op_d    = '0;
        ex_funct_d     = '0;
        ex_alu_src_d   = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_branch_d    = 1'b0;
        ex_illegal_d   = 1'b0;
        if (!bus.flush && !stall) begin
            ex_valid_d   = bus.id_valid;
            ex_pc_d      = bus.id_pc;
            ex_rs_data_d = read_operand(rs, bus.rf_rdata1, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
            ex_rt_data_d = read_operand(rt, bus.rf_rdata2, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
            ex_imm_d     = imm_sext;
            ex_rs_d      = rs;
            ex_rt_d      = rt;
            ex_dest_d    = dec_dest;
            if (bus.id_valid) begin
                ex_alu_op_d    = dec_alu_op;
                ex_funct_d     = dec_funct;
                ex_alu_src_d   = dec_alu_src;
                ex_mem_read_d  = dec_mem_read;
                ex_mem_write_d = dec_mem_write;
                ex_reg_write_d = dec_reg_write;
                ex_branch_d    = dec_branch;
                ex_illegal_d   = dec_illegal;
            end
        end
    end

    // ID/EX pipeline register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= RESET_PC;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_alu_op_q    <= '0;
            ex_funct_q     <= '0;
            ex_alu_src_q   <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_funct_q     <= ex_funct_d;
            ex_alu_src_q   <= ex_alu_src_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_branch_q    <= ex_branch_d;
            ex_illegal_q   <= ex_illegal_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_dest      = ex_dest_q;
    assign bus.ex_alu_op    = ex_alu_op_q;
    assign bus.ex_funct     = ex_funct_q;
    assign bus.ex_alu_src   = ex_alu_src_q;
    assign bus.ex_mem_read  = ex_mem_read_q;
    assign bus.ex_mem_write = ex_mem_write_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_branch    = ex_branch_q;
    assign bus.ex_illegal   = ex_illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized instruction stream.
module tb_id_ex_stage;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_if bus ();

    id_ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected EX register contents
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src, mem_read, mem_write, reg_write, branch, illegal;
    } ex_t;

    ex_t  m;
    logic m_data_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t e;
        e.valid = 0; e.pc = 0; e.rs_data = 0; e.rt_data = 0; e.imm = 0;
        e.rs = 0; e.rt = 0; e.dest = 0; e.alu_op = 0; e.funct = 0;
        e.alu_src = 0; e.mem_read = 0; e.mem_write = 0; e.reg_write = 0;
        e.branch = 0; e.illegal = 0;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Operand as the architecture sees it this cycle
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rd,
                                            input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return rd;
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".valid"},     32'(bus.ex_valid),     32'(m.valid));
        chk({tag, ".pc"},        bus.ex_pc,             m.pc);
        chk({tag, ".alu_op"},    32'(bus.ex_alu_op),    32'(m.alu_op));
        chk({tag, ".alu_src"},   32'(bus.ex_alu_src),   32'(m.alu_src));
        chk({tag, ".mem_read"},  32'(bus.ex_mem_read),  32'(m.mem_read));
        chk({tag, ".mem_write"}, 32'(bus.ex_mem_write), 32'(m.mem_write));
        chk({tag, ".reg_write"}, 32'(bus.ex_reg_write), 32'(m.reg_write));
        chk({tag, ".branch"},    32'(bus.ex_branch),    32'(m.branch));
        chk({tag, ".illegal"},   32'(bus.ex_illegal),   32'(m.illegal));
        if (m_data_known) begin
            chk({tag, ".rs_data"}, bus.ex_rs_data,     m.rs_data);
            chk({tag, ".rt_data"}, bus.ex_rt_data,     m.rt_data);
            chk({tag, ".imm"},     bus.ex_imm,         m.imm);
            chk({tag, ".rs"},      32'(bus.ex_rs),     32'(m.rs));
            chk({tag, ".rt"},      32'(bus.ex_rt),     32'(m.rt));
            chk({tag, ".dest"},    32'(bus.ex_dest),   32'(m.dest));
            if (m.valid && m.alu_op == 2'b10)
                chk({tag, ".funct"}, 32'(bus.ex_funct), 32'(m.funct));
        end
    endtask

    // One cycle: drive at negedge, check ID-side outputs, clock, check EX register.
    task automatic step(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        output logic stalled);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       uses_rt, st;
        ex_t        n;
        bus.id_valid = v;  bus.id_instr = instr; bus.id_pc = pc; bus.flush = fl;
        bus.rf_rdata1 = rd1; bus.rf_rdata2 = rd2;
        bus.wb_we = we; bus.wb_waddr = wa; bus.wb_wdata = wd;
        #1;
        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
        uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        st = !fl && v && m.valid && m.mem_read && m.dest != 0 &&
             (m.dest == rs || (uses_rt && m.dest == rt));
        chk({tag, ".raddr1"}, 32'(bus.rf_raddr1), 32'(rs));
        chk({tag, ".raddr2"}, 32'(bus.rf_raddr2), 32'(rt));
        chk({tag, ".stall"},  32'(bus.id_stall),  32'(st));
        stalled = st;
        n = zero_ex();
        if (fl || st) begin
            m_data_known = 1'b1;
        end else begin
            n.valid = v; n.pc = pc; n.rs = rs; n.rt = rt;
            n.imm = 32'($signed(instr[15:0]));
            n.rs_data = operand(rs, rd1, we, wa, wd);
            n.rt_data = operand(rt, rd2, we, wa, wd);
            case (op)
                6'h00: begin n.dest = instr[15:11]; n.reg_write = 1; n.alu_op = 2'b10; n.funct = instr[5:0]; end
                6'h08: begin n.dest = rt; n.alu_src = 1; n.reg_write = 1; end
                6'h23: begin n.dest = rt; n.alu_src = 1; n.mem_read = 1; n.reg_write = 1; end
                6'h2B: begin n.alu_src = 1; n.mem_write = 1; end
                6'h04: begin n.branch = 1; n.alu_op = 2'b01; end
                default: n.illegal = 1;
            endcase
            if (n.dest == 0) n.reg_write = 0;
            if (!v) begin
                n.alu_op = 0; n.funct = 0; n.alu_src = 0; n.mem_read = 0; n.mem_write = 0;
                n.reg_write = 0; n.branch = 0; n.illegal = 0;
            end
            m_data_known = v;
        end
        m = n;
        @(posedge clk);
        #1;
        cmp_all(tag);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        int rs, rt, rd;
        rs = int'($urandom_range(0, 3)); rt = int'($urandom_range(0, 3)); rd = int'($urandom_range(0, 3));
        k = int'($urandom_range(0, 5));
        case (k)
            0: return enc_r(rs, rt, rd, int'($urandom_range(0, 63)));
            1: return enc_i(8'h08, rs, rt, int'($urandom));
            2: return enc_i(8'h23, rs, rt, int'($urandom));
            3: return enc_i(8'h2B, rs, rt, int'($urandom));
            4: return enc_i(8'h04, rs, rt, int'($urandom));
            default: return {6'h3F - 6'($urandom_range(0, 2)), 26'($urandom)};
        endcase
    endfunction

    initial begin
        logic        s;
        logic [31:0] instr;
        logic        v;

        reset = 1'b1;
        bus.id_valid = 0; bus.id_instr = 0; bus.id_pc = 0; bus.flush = 0;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
        m = zero_ex(); m.pc = RST_PC; m_data_known = 1'b1;
        @(negedge clk);
        cmp_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // addi $8,$0,-5
        step("addi", 1, 32'h2008FFFB, 32'h100, 0, 32'hCAFE, 32'hBEEF, 0, 0, 0, s);
        chk("addi_dest", 32'(bus.ex_dest), 32'd8);
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFB);
        chk("addi_rs_data", bus.ex_rs_data, 32'd0);

        // lw $9,0($8) then add $10,$9,$9 stalls once
        step("lw", 1, enc_i(8'h23, 8, 9, 0), 32'h104, 0, 32'h1000, 32'h0, 0, 0, 0, s);
        step("ld_use", 1, enc_r(9, 9, 10, 32), 32'h108, 0, 32'h7, 32'h7, 0, 0, 0, s);
        chk("ld_use_stall", 32'(s), 32'd1);
        chk("ld_use_bubble", 32'(bus.ex_valid), 32'd0);
        step("ld_use_issue", 1, enc_r(9, 9, 10, 32), 32'h108, 0, 32'h7, 32'h7, 0, 0, 0, s);
        chk("ld_use_issue_valid", 32'(bus.ex_valid), 32'd1);

        // write-back bypass on $5
        step("bypass", 1, enc_r(5, 6, 7, 32), 32'h10C, 0, 32'hDEAD, 32'h66, 1, 5, 32'h12345678, s);
        chk("bypass_rs", bus.ex_rs_data, 32'h12345678);

        // flush wins over a pending load-use stall
        step("lw2", 1, enc_i(8'h23, 1, 9, 4), 32'h110, 0, 32'h20, 0, 0, 0, 0, s);
        step("flush", 1, enc_i(8'h23, 9, 11, 0), 32'h114, 1, 32'h30, 0, 0, 0, 0, s);
        chk("flush_nostall", 32'(s), 32'd0);
        chk("flush_memread", 32'(bus.ex_mem_read), 32'd0);

        // illegal opcode
        step("illegal", 1, 32'hFC00_0000 | enc_r(3, 3, 3, 0), 32'h118, 0, 1, 2, 0, 0, 0, s);
        chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);

        // randomized stream; a stalled instruction is re-presented as IF/ID would
        instr = rand_instr(); v = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step("rand", v, instr, $urandom, ($urandom_range(0, 9) == 0),
                 $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom, s);
            if (!s) begin
                instr = rand_instr();
                v = ($urandom_range(0, 7) != 0);
            end
        end

        // asynchronous reset between edges
        step("pre_rst", 1, enc_i(8'h08, 1, 2, 3), 32'h200, 0, 5, 6, 0, 0, 0, s);
        #2;
        reset = 1'b1;
        #1;
        m = zero_ex(); m.pc = RST_PC; m_data_known = 1'b1;
        cmp_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 1, enc_i(8'h23, 0, 4, 8), 32'h300, 0, 0, 0, 0, 0, 0, s);
        step("post_rst_use", 1, enc_r(4, 0, 5, 33), 32'h304, 0, 9, 0, 0, 0, 0, s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_valid  in  1  IF/ID holds a valid instruction.
REQ-005 id_instr  in  32  MIPS instruction from IF/ID.
REQ-006 id_pc  in  32  PC of id_instr.
REQ-007 flush  in  1  discard the ID instruction (taken branch from EX).
REQ-008 rf_raddr1, rf_raddr2  out  5 each  register-file read addresses (rs, rt).
REQ-009 rf_rdata1, rf_rdata2  in  32 each  combinational register-file read data.
REQ-010 wb_we, wb_waddr, wb_wdata  in  1/5/32  write-back port driving the register file this cycle.
REQ-011 id_stall  out  1  hold PC and IF/ID this cycle.
REQ-012 ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  1/32/32/32/32  registered EX operands.
REQ-013 ex_rs, ex_rt, ex_dest  out  5 each  registered source/destination register numbers.
REQ-014 ex_alu_op  out  2  00 add, 01 sub, 10 use funct; ex_funct  out  6.
REQ-015 ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_illegal  out  1 each  registered controls.

Function
REQ-016 rf_raddr1 SHALL be id_instr[25:21]; rf_raddr2 SHALL be id_instr[20:16]; both combinational.
REQ-017 Decode: opcode 0x00 R-type (dest=[15:11], reg_write, alu_op 10); 0x08 addi (dest=[20:16], alu_src, reg_write, op 00); 0x23 lw (dest=[20:16], alu_src, mem_read, reg_write, op 00); 0x2B sw (alu_src, mem_write, op 00); 0x04 beq (branch, op 01).
REQ-018 Any other opcode SHALL produce ex_illegal=1 with all other controls 0 and ex_dest=0.
REQ-019 ex_imm SHALL be id_instr[15:0] sign-extended to 32 bits.
REQ-020 Operand read SHALL return 0 when address is 0, regardless of rf_rdata.
REQ-021 Else if wb_we=1 and wb_waddr equals the address (non-zero), operand SHALL be wb_wdata (same-cycle write bypass).
REQ-022 Else operand SHALL be rf_rdata1/rf_rdata2.
REQ-023 Load-use hazard: id_stall=1 combinationally when id_valid, ex_valid, ex_mem_read, ex_dest!=0, and ex_dest equals rs or (rt for R-type/sw/beq); else 0.
REQ-024 ex_reg_write SHALL be forced 0 when dest is 0.
REQ-025 Each rising edge: if flush=1, EX register SHALL load a bubble (ex_valid=0, all controls 0) and id_stall SHALL be 0 that cycle; flush has priority over stall.
REQ-026 Else if id_stall=1, EX register SHALL load a bubble; IF/ID contents are held externally and re-decoded next cycle.
REQ-027 Else EX register SHALL load decoded values with ex_valid=id_valid; if id_valid=0 all controls SHALL be 0.
REQ-028 Latency SHALL be exactly one cycle from ID to EX outputs; no combinational path from id_* to ex_*.
REQ-029 Data fields (pc, operands, imm, register numbers) in a bubble SHALL be don't-care-but-deterministic: loaded as zero.

Reset
REQ-030 While reset=1, all ex_* outputs SHALL be 0 except ex_pc=RESET_PC, asynchronously, independent of clk.
REQ-031 First edge after reset deassertion SHALL follow REQ-025..027 normally; a stall cannot arise from reset state since ex_valid=0.

Verification
REQ-032 addi $t0($8),$0,-5 (0x2008FFFB), valid -> next cycle ex_dest=8, ex_imm=0xFFFFFFFB, ex_alu_src=1, ex_reg_write=1, ex_rs_data=0.
REQ-033 lw $9,0($8) in EX then add $10,$9,$9 in ID -> id_stall=1, next ex_valid=0; following cycle add issues with ex_valid=1.
REQ-034 Reading $5 while wb_we=1, wb_waddr=5, wb_wdata=0x12345678, rf_rdata1=0xDEAD -> ex_rs_data=0x12345678.
REQ-035 flush=1 with valid lw in ID and a load-use hazard present -> id_stall=0, next ex_valid=0, ex_mem_read=0.
REQ-036 Opcode 0x3F valid -> ex_illegal=1, ex_reg_write=0, ex_mem_write=0.
REQ-037 Assert reset mid-stream between edges -> ex_valid=0 and ex_pc=RESET_PC immediately, before next clk edge.
